// File: rtl/tick_event_logger.sv
// ---------------------------------------------------------------------------
// tick_event_logger
//
// Captures one 64-bit entry {sample, ts_field} into an on-chip FIFO on every
// rising edge of the period tick while en is high. The host drains the FIFO
// as a stream of 16-bit words (ts[15:0], ts[31:16], ts[47:32], sample), one
// word per rd_en, with a single cycle of read latency.
//
// Optional feature (macro TICK_LOGGER_DELTA_EN):
//   defined   : ts_field = timestamp - last_ts (mod 2^48). last_ts follows
//               every successful push and is cleared on reset and on the
//               rising edge of en, so a run starts with an absolute stamp.
//   undefined : ts_field = timestamp; no last_ts register.
//
// Ports
//   clk        in   system clock, posedge
//   rst_n      in   asynchronous active-low reset
//   en         in   capture enable
//   tick       in   period tick (level; only its rising edge captures)
//   timestamp  in   48-bit free-running timestamp
//   sample     in   16-bit data word stored with the timestamp
//   rd_en      in   request the next 16-bit output word
//   rd_data    out  registered output word
//   rd_valid   out  1-cycle pulse, rd_data holds a fresh word
//   count      out  complete entries stored (0..DEPTH)
//   empty      out  count == 0
//   full       out  count == DEPTH
//   overflow   out  sticky: a capture was dropped on a full FIFO
//   clr_ovf    in   synchronous clear of overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module tick_event_logger #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          tick,
    input  logic [47:0]   timestamp,
    input  logic [15:0]   sample,
    input  logic          rd_en,
    output logic [15:0]   rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    input  logic          clr_ovf
);

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic          tick_d;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    word_idx;
    logic [63:0]   mem [DEPTH];

    logic          cap;
    logic          push;
    logic          drop;
    logic          rd_fire;
    logic          pop;
    logic [47:0]   ts_field;
    logic [15:0]   word_sel;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // One capture per tick rise. tick_d runs regardless of en, so a tick that
    // is already high when en rises does not capture until its next rise.
    assign cap  = tick & ~tick_d & en;
    // full is the registered value, so a capture that coincides with the
    // final-word pop of a full FIFO is still dropped.
    assign push = cap & ~full;
    assign drop = cap &  full;

    assign rd_fire = rd_en & ~empty;
    assign pop     = rd_fire & (word_idx == 2'd3);

`ifdef TICK_LOGGER_DELTA_EN
    logic        en_d;
    logic        en_rise;
    logic [47:0] last_ts;

    assign en_rise = en & ~en_d;
    // A capture in the very cycle en rises must see the cleared reference,
    // so the clear is folded in combinationally as well.
    assign ts_field = timestamp - (en_rise ? 48'd0 : last_ts);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d    <= 1'b0;
            last_ts <= '0;
        end else begin
            en_d <= en;
            if (push) begin
                last_ts <= timestamp;
            end else if (en_rise) begin
                last_ts <= '0;
            end
        end
    end
`else
    assign ts_field = timestamp;
`endif

    // NOTE: the storage array has no reset; entries are only ever read after
    // being written, and only pointers/flags need a defined reset state.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {sample, ts_field};
        end
    end

    // NOTE: every variable driven here gets a default first so no latch is
    // inferred when a case arm is missed.
    always_comb begin
        word_sel = mem[rd_ptr][15:0];
        case (word_idx)
            2'd1:    word_sel = mem[rd_ptr][31:16];
            2'd2:    word_sel = mem[rd_ptr][47:32];
            2'd3:    word_sel = mem[rd_ptr][63:48];
            default: word_sel = mem[rd_ptr][15:0];
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop in
    // this block samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            word_idx <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            tick_d   <= tick;
            rd_valid <= rd_fire;

            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end

            if (rd_fire) begin
                rd_data  <= word_sel;
                word_idx <= word_idx + 2'd1;   // 3 wraps back to 0 on the pop
            end

            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end

            // count tracks complete entries only; push+pop cancels out.
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tick_event_logger.sv
// ---------------------------------------------------------------------------
// tb_tick_event_logger
//
// Directed bench for tick_event_logger (DEPTH=16). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point, i.e. after
// the DUT has updated on that edge. Expected values are hand-computed; the
// timestamp-field test selects absolute or delta expectations according to
// TICK_LOGGER_DELTA_EN.
// ---------------------------------------------------------------------------
module tb_tick_event_logger;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          tick;
    logic [47:0]   timestamp;
    logic [15:0]   sample;
    logic          rd_en;
    logic [15:0]   rd_data;
    logic          rd_valid;
    logic [AW:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;
    logic          clr_ovf;

    int errors = 0;
    int checks = 0;

    tick_event_logger #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .tick      (tick),
        .timestamp (timestamp),
        .sample    (sample),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One tick rise (captured on the next edge), then tick low for a cycle.
    task automatic do_tick(input logic [47:0] ts, input logic [15:0] s);
        timestamp = ts;
        sample    = s;
        tick      = 1'b1;
        step();
        tick      = 1'b0;
        step();
    endtask

    // Drop and re-raise en so a new run starts.
    task automatic restart_run();
        en = 1'b0;
        step();
        en = 1'b1;
        step();
    endtask

    // Four back-to-back reads; assembles the entry and reports whether every
    // word came with rd_valid.
    task automatic read_entry(output logic [63:0] e, output logic all_valid);
        e         = '0;
        all_valid = 1'b1;
        rd_en     = 1'b1;
        for (int w = 0; w < 4; w++) begin
            step();
            e[w*16 +: 16] = rd_data;
            if (rd_valid !== 1'b1) all_valid = 1'b0;
        end
        rd_en = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #3;
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
            rd_valid !== 1'b0 || rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset: count=%0d empty=%b full=%b ovf=%b valid=%b data=%h, expected 0 1 0 0 0 0000",
                     count, empty, full, overflow, rd_valid, rd_data);
        end
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [15:0] exp_w [4];
        exp_w = '{16'h5678, 16'h1234, 16'h0000, 16'hBEEF};
        en = 1'b1;
        step();
        do_tick(48'h0000_1234_5678, 16'hBEEF);
        checks++;
        if (count !== 5'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL basic_count: count=%0d empty=%b, expected 1 0", count, empty);
        end
        rd_en = 1'b1;
        for (int w = 0; w < 4; w++) begin
            step();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== exp_w[w]) begin
                errors++;
                $display("FAIL basic_w%0d: data=%h valid=%b, expected %h valid 1",
                         w, rd_data, rd_valid, exp_w[w]);
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL basic_empty: empty=%b count=%0d, expected 1 0", empty, count);
        end
        // rd_en held while empty: ignored, data holds.
        step();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL read_when_empty: valid=%b data=%h, expected 0 beef", rd_valid, rd_data);
        end
        rd_en = 1'b0;
        step();
    endtask

    task automatic test_long_tick();
        logic [63:0] e;
        logic        v;
        restart_run();
        timestamp = 48'h0000_0000_0042;
        sample    = 16'h1111;
        tick      = 1'b1;
        for (int i = 0; i < 5; i++) step();
        tick = 1'b0;
        step();
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL long_tick_count: count=%0d, expected 1", count);
        end
        read_entry(e, v);
        checks++;
        if (v !== 1'b1 || e !== {16'h1111, 48'h0000_0000_0042} || empty !== 1'b1) begin
            errors++;
            $display("FAIL long_tick_entry: entry=%h valid=%b empty=%b, expected 1111000000000042 1 1",
                     e, v, empty);
        end
    endtask

    task automatic test_en_low();
        logic [63:0] e;
        logic        v;
        en = 1'b0;
        step();
        for (int i = 0; i < 3; i++) do_tick(48'h0000_0000_0500 + 48'(i), 16'h9999);
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL en_low_count: count=%0d, expected 0", count);
        end
        // tick already high when en rises: no capture
        tick = 1'b1;
        step();
        en = 1'b1;
        step();
        step();
        checks++;
        if (count !== '0) begin
            errors++;
            $display("FAIL tick_high_at_en: count=%0d, expected 0", count);
        end
        tick = 1'b0;
        step();
        do_tick(48'h0000_0000_0777, 16'h2222);
        checks++;
        if (count !== 5'd1) begin
            errors++;
            $display("FAIL next_rise_count: count=%0d, expected 1", count);
        end
        read_entry(e, v);
        checks++;
        if (v !== 1'b1 || e !== {16'h2222, 48'h0000_0000_0777}) begin
            errors++;
            $display("FAIL next_rise_entry: entry=%h valid=%b, expected 2222000000000777 1", e, v);
        end
    endtask

    task automatic test_overflow();
        restart_run();
        for (int i = 0; i < 17; i++) begin
            do_tick(48'h0000_0000_0100 + 48'(i), 16'(i));
            if (i == 15) begin
                checks++;
                if (full !== 1'b1 || overflow !== 1'b0 || count !== 5'd16) begin
                    errors++;
                    $display("FAIL fill_16: full=%b ovf=%b count=%0d, expected 1 0 16",
                             full, overflow, count);
                end
            end
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL overflow_17: full=%b ovf=%b count=%0d, expected 1 1 16",
                     full, overflow, count);
        end
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL clr_ovf: ovf=%b full=%b, expected 0 1", overflow, full);
        end
    endtask

    task automatic test_pop_with_capture();
        rd_en = 1'b1;
        step();
        checks++;
        if (rd_data !== 16'h0100 || rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_ts_w0: data=%h valid=%b, expected 0100 1", rd_data, rd_valid);
        end
        step();
        step();
        // w3 pop and tick rise in the same cycle
        timestamp = 48'h0000_0000_0999;
        sample    = 16'hDEAD;
        tick      = 1'b1;
        step();
        rd_en = 1'b0;
        tick  = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd15 || full !== 1'b0 || rd_data !== 16'h0000) begin
            errors++;
            $display("FAIL pop_capture: ovf=%b count=%0d full=%b data=%h, expected 1 15 0 0000",
                     overflow, count, full, rd_data);
        end
        step();
        do_tick(48'h0000_0000_0200, 16'h0ABC);
        checks++;
        if (count !== 5'd16 || full !== 1'b1) begin
            errors++;
            $display("FAIL refill: count=%0d full=%b, expected 16 1", count, full);
        end
        // clear and drop in the same cycle: set wins
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        timestamp = 48'h0000_0000_0300;
        sample    = 16'h5555;
        tick      = 1'b1;
        clr_ovf   = 1'b1;
        step();
        tick    = 1'b0;
        clr_ovf = 1'b0;
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL set_wins: ovf=%b count=%0d, expected 1 16", overflow, count);
        end
        step();
    endtask

    task automatic test_drain_order();
        logic [15:0] exp_s;
        rd_en = 1'b1;
        for (int k = 0; k < 64; k++) begin
            step();
            if (k % 4 == 3) begin
                exp_s = (k / 4 < 15) ? 16'(k / 4 + 1) : 16'h0ABC;
                checks++;
                if (rd_data !== exp_s || rd_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL drain_entry%0d: sample=%h valid=%b, expected %h 1",
                             k / 4, rd_data, rd_valid, exp_s);
                end
            end
        end
        rd_en = 1'b0;
        checks++;
        if (empty !== 1'b1 || count !== '0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b count=%0d, expected 1 0", empty, count);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        logic [63:0] e;
        logic        v;
        restart_run();
        do_tick(48'h0000_0000_0055, 16'h3333);
        rd_en = 1'b1;
        step();
        step();
        rd_en = 1'b0;            // word index is now 2
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_read: count=%0d empty=%b full=%b ovf=%b valid=%b, expected 0 1 0 0 0",
                     count, empty, full, overflow, rd_valid);
        end
        step();
        rst_n = 1'b1;
        step();
        do_tick(48'h0000_ABCD_0123, 16'h4444);
        read_entry(e, v);
        checks++;
        if (v !== 1'b1 || e !== {16'h4444, 48'h0000_ABCD_0123}) begin
            errors++;
            $display("FAIL after_reset_entry: entry=%h valid=%b, expected 44440000abcd0123 1", e, v);
        end
    endtask

    task automatic test_ts_field();
        logic [63:0] e;
        logic        v;
        logic [47:0] exp_a [3];
        logic [47:0] exp_b [2];
`ifdef TICK_LOGGER_DELTA_EN
        exp_a = '{48'd100, 48'd250, 48'd1};
        exp_b = '{48'hFFFF_FFFF_FFFF, 48'd3};
`else
        exp_a = '{48'd100, 48'd350, 48'd351};
        exp_b = '{48'hFFFF_FFFF_FFFF, 48'd2};
`endif
        restart_run();
        do_tick(48'd100, 16'h0001);
        do_tick(48'd350, 16'h0002);
        do_tick(48'd351, 16'h0003);
        for (int i = 0; i < 3; i++) begin
            read_entry(e, v);
            checks++;
            if (v !== 1'b1 || e[47:0] !== exp_a[i] || e[63:48] !== 16'(i + 1)) begin
                errors++;
                $display("FAIL ts_field%0d: entry=%h valid=%b, expected ts %h sample %0d",
                         i, e, v, exp_a[i], i + 1);
            end
        end
        restart_run();
        do_tick(48'hFFFF_FFFF_FFFF, 16'h0005);
        do_tick(48'd2, 16'h0006);
        for (int i = 0; i < 2; i++) begin
            read_entry(e, v);
            checks++;
            if (v !== 1'b1 || e[47:0] !== exp_b[i] || e[63:48] !== 16'(i + 5)) begin
                errors++;
                $display("FAIL ts_wrap%0d: entry=%h valid=%b, expected ts %h sample %0d",
                         i, e, v, exp_b[i], i + 5);
            end
        end
    endtask

    initial begin
        en        = 1'b0;
        tick      = 1'b0;
        timestamp = '0;
        sample    = '0;
        rd_en     = 1'b0;
        clr_ovf   = 1'b0;

        test_reset();
        test_basic();
        test_long_tick();
        test_en_low();
        test_overflow();
        test_pop_with_capture();
        test_drain_order();
        test_reset_mid_read();
        test_ts_field();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
